// File: rtl/tree_adder_pkg.sv
// Shared definitions for the tree adder front end and its wrapper.
//   collector_state_e : operand collector FSM states
//   count_width(n)    : bits needed to hold a count of 0..n
package tree_adder_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } collector_state_e;

    function automatic int count_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/tree_operand_collector.sv
// Streaming operand collector for the binary tree adder.
// Accepts one P-bit operand per cycle and assembles a group of up to
// INPUTS_AMOUNT operands into one registered vector. Groups closed early by
// in_last are zero-padded, so the downstream sum is unaffected.
//
// state | meaning
// FILL  | accepting operands into slots; in_ready=1, out_valid=0
// HOLD  | presenting the assembled vector; in_ready=0, out_valid=1
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand handshake
//   in_data               operand
//   in_last               operand closes the current group
//   in_signed             group signed mode, taken from the first operand
//   out_valid/out_ready   vector handshake
//   out_data              vector, element 0 = first operand of the group
//   out_count             number of real (non-pad) elements
//   out_signed            signed flag of the group
module tree_operand_collector
    import tree_adder_pkg::*;
#(
    parameter int INPUTS_AMOUNT = 8,
    parameter int P             = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [P-1:0]                           in_data,
    input  logic                                   in_last,
    input  logic                                   in_signed,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [P-1:0]                           out_data [INPUTS_AMOUNT],
    output logic [count_width(INPUTS_AMOUNT)-1:0]  out_count,
    output logic                                   out_signed
);

    localparam int              CW       = count_width(INPUTS_AMOUNT);
    localparam logic [CW-1:0]   LAST_IDX = CW'(INPUTS_AMOUNT - 1);

    if (INPUTS_AMOUNT < 2 || (INPUTS_AMOUNT & (INPUTS_AMOUNT - 1)) != 0) begin : g_bad_param
        $fatal(1, "tree_operand_collector: INPUTS_AMOUNT must be a power of 2 and >= 2");
    end

    collector_state_e r_state;
    collector_state_e w_next_state;
    logic [CW-1:0]    r_idx;
    logic [CW-1:0]    r_count;
    logic             r_sgn;
    logic [P-1:0]     r_slots [INPUTS_AMOUNT];
    logic             w_accept;
    logic             w_close;

    assign w_accept = in_valid && (r_state == FILL);
    assign w_close  = in_last || (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL: if (w_accept && w_close) w_next_state = HOLD;
            HOLD: if (out_ready)           w_next_state = FILL;
            default:                       w_next_state = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_count <= '0;
            r_sgn   <= 1'b0;
            for (int i = 0; i < INPUTS_AMOUNT; i++) begin
                r_slots[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < INPUTS_AMOUNT; i++) begin
                if (r_idx == CW'(i)) r_slots[i] <= in_data;
            end
            if (r_idx == '0) r_sgn <= in_signed;
            r_idx <= r_idx + CW'(1);
            if (w_close) r_count <= r_idx + CW'(1);
        end else if (r_state == HOLD && out_ready) begin
            // Clearing on release keeps unwritten slots of the next short
            // group at zero, which is what makes the padding neutral.
            r_idx <= '0;
            for (int i = 0; i < INPUTS_AMOUNT; i++) begin
                r_slots[i] <= '0;
            end
        end
    end

    assign in_ready   = (r_state == FILL);
    assign out_valid  = (r_state == HOLD);
    assign out_data   = r_slots;
    assign out_count  = r_count;
    assign out_signed = r_sgn;

endmodule

// File: tb/tb_tree_operand_collector.sv
module tb_tree_operand_collector;
    import tree_adder_pkg::*;

    localparam int N  = 4;
    localparam int P  = 8;
    localparam int CW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [P-1:0]   in_data = '0;
    logic           in_last = 1'b0;
    logic           in_signed = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [P-1:0]   out_data [N];
    logic [CW-1:0]  out_count;
    logic           out_signed;

    tree_operand_collector #(.INPUTS_AMOUNT(N), .P(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_signed  (in_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_signed (out_signed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0][P-1:0] d;
        logic [CW-1:0]       c;
        logic                s;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic exp_t mk(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d,
                                input logic [CW-1:0] cnt, input logic s);
        exp_t e;
        e.d[0] = a; e.d[1] = b; e.d[2] = c; e.d[3] = d;
        e.c = cnt;
        e.s = s;
        return e;
    endfunction

    function automatic logic [N-1:0][P-1:0] pack_out();
        logic [N-1:0][P-1:0] v;
        for (int i = 0; i < N; i++) v[i] = out_data[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Monitor: every completed output handshake is checked against the
    // oldest expected vector.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_vector", 64'(pack_out()), 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data",   64'(pack_out()), 64'(e.d));
                chk("out_count",  64'(out_count),  64'(e.c));
                chk("out_signed", 64'(out_signed), 64'(e.s));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [7:0] d, input logic l, input logic s);
        int guard;
        guard = 0;
        in_valid = 1'b1; in_data = d; in_last = l; in_signed = s;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_signed = 1'b0;
    endtask

    task automatic check_zero_out(input string name);
        chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_in_ready"},  64'(in_ready),  64'd1);
        chk({name, "_out_data"},  64'(pack_out()), 64'd0);
    endtask

    initial begin
        int sum;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        check_zero_out("reset");
        chk("reset_out_count",  64'(out_count),  64'd0);
        chk("reset_out_signed", 64'(out_signed), 64'd0);

        // full group
        exp_q.push_back(mk(8'h01, 8'h02, 8'h03, 8'h04, 3'd4, 1'b0));
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        chk("full_no_early_valid", 64'(out_valid), 64'd0);
        send(8'h04, 1'b1, 1'b0);
        chk("full_latency_valid", 64'(out_valid), 64'd1);
        chk("full_hold_in_ready", 64'(in_ready),  64'd0);
        @(negedge clk);
        chk("full_in_ready_back", 64'(in_ready),  64'd1);
        chk("full_valid_dropped", 64'(out_valid), 64'd0);

        // short group, signed
        exp_q.push_back(mk(8'hFF, 8'h80, 8'h00, 8'h00, 3'd2, 1'b1));
        send(8'hFF, 1'b0, 1'b1);
        send(8'h80, 1'b1, 1'b0);
        sum = 0;
        for (int i = 0; i < N; i++) sum += int'($signed(out_data[i]));
        chk("short_signed_sum", 64'(sum), 64'(-129));
        @(negedge clk);

        // backpressure with in_valid held high
        out_ready = 1'b0;
        exp_q.push_back(mk(8'h10, 8'h11, 8'h12, 8'h13, 3'd4, 1'b0));
        send(8'h10, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h12, 1'b0, 1'b0);
        send(8'h13, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0; in_signed = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 64'(out_valid),  64'd1);
            chk("bp_in_ready",  64'(in_ready),   64'd0);
            chk("bp_out_data",  64'(pack_out()), 64'(mk(8'h10, 8'h11, 8'h12, 8'h13, 3'd4, 1'b0).d));
            chk("bp_out_count", 64'(out_count),  64'd4);
            @(negedge clk);
        end
        exp_q.push_back(mk(8'h55, 8'h56, 8'h57, 8'h58, 3'd4, 1'b0));
        out_ready = 1'b1;
        send(8'h55, 1'b0, 1'b0);
        send(8'h56, 1'b0, 1'b0);
        send(8'h57, 1'b0, 1'b0);
        send(8'h58, 1'b1, 1'b0);
        @(negedge clk);

        // sign latched on first operand only
        exp_q.push_back(mk(8'h21, 8'h22, 8'h23, 8'h24, 3'd4, 1'b1));
        send(8'h21, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b0);
        send(8'h23, 1'b0, 1'b0);
        send(8'h24, 1'b1, 1'b0);
        @(negedge clk);

        // reset mid-group, asserted between edges
        send(8'hAA, 1'b0, 1'b1);
        send(8'hBB, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero_out("midrst");
        chk("midrst_out_signed", 64'(out_signed), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(mk(8'h0A, 8'h0A, 8'h0A, 8'h0A, 3'd4, 1'b0));
        send(8'h0A, 1'b0, 1'b0);
        send(8'h0A, 1'b0, 1'b0);
        send(8'h0A, 1'b0, 1'b0);
        send(8'h0A, 1'b1, 1'b0);
        @(negedge clk);

        // single-element group
        exp_q.push_back(mk(8'h7F, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0));
        send(8'h7F, 1'b1, 1'b0);
        chk("single_latency_valid", 64'(out_valid), 64'd1);
        repeat (3) @(negedge clk);

        chk("all_vectors_seen", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tree_operand_collector.md
# tree_operand_collector

Streaming front end for the binary tree adder. It accepts P-bit operands one per cycle on a valid/ready handshake and assembles them into an INPUTS_AMOUNT-wide vector. It then presents that vector, together with a signed-mode flag, as one registered word on a second valid/ready handshake. Short groups terminated by `in_last` are zero-padded, so the downstream reduction result is unaffected.

## Interface
- INPUTS_AMOUNT, 8: vector width in elements; must be a power of 2 and ≥ 2 (elaboration `$fatal` otherwise).
- P, 8: element width in bits.
- CW (localparam) = $clog2(INPUTS_AMOUNT)+1: count width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand valid.
- in_ready  out  1  collector can accept an operand.
- in_data  in  P  operand.
- in_last  in  1  operand closes the current group.
- in_signed  in  1  signed mode for the group; sampled with its first operand.
- out_valid  out  1  assembled vector valid.
- out_ready  in  1  consumer accepts the vector.
- out_data  out  P × [INPUTS_AMOUNT]  unpacked vector; element 0 = first operand received.
- out_count  out  CW  number of real (non-pad) elements, 1..INPUTS_AMOUNT.
- out_signed  out  1  signed flag of the group.

## Operation
- FSM states: FILL, HOLD.
- **FILL**
  - in_ready = 1; out_valid = 0.
  - On in_valid && in_ready: write in_data to slot idx, then idx++.
  - If idx == 0, latch in_signed into sgn_q.
  - If in_last, or idx == INPUTS_AMOUNT-1: out_count ← idx+1, go to HOLD.
- **HOLD**
  - in_ready = 0; out_valid = 1.
  - out_data, out_count and out_signed are held stable until out_valid && out_ready.
  - On that handshake: clear all slots to 0, set idx ← 0, go to FILL.
- **Padding:** slots ≥ out_count read as 0. Zero is neutral for both signed and unsigned summation.
- **in_signed on non-first operands** is ignored; the group's sign is fixed by its first operand.
- **in_last on the INPUTS_AMOUNT-th operand:** same behaviour as a full vector; no empty extra vector is emitted.
- **No empty groups:** a vector always contains ≥ 1 real element.
- **in_data while in_valid = 0** is ignored; no slot is written.
- **Reset (async, at any time, including mid-group):**
  - state ← FILL, idx ← 0, all slots ← 0, sgn_q ← 0, out_count ← 0.
  - Outputs after reset: out_valid = 0, in_ready = 1, out_data all 0, out_signed = 0, out_count = 0.
  - A partially collected group is discarded.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from in_* to out_*, or from out_ready to in_ready.
- **Latency:** out_valid rises the cycle after the closing operand handshake.
- **Throughput:**
  - Full vector: INPUTS_AMOUNT accept cycles + ≥ 1 HOLD cycle.
  - With out_ready held high: one vector per INPUTS_AMOUNT+1 cycles.
  - in_ready returns high the cycle after the output handshake.
- **Backpressure:** while out_ready is low, the collector stays in HOLD indefinitely with outputs frozen, and in_ready stays low.
- **No overlap:** the input and output handshakes can never complete in the same cycle, because in_ready = 0 in HOLD.
- **Consumer reaction:** out_ready may be asserted before out_valid; the handshake completes in the first HOLD cycle.

## Structure
- **Shared package `tree_adder_pkg`:**
  - `collector_state_e` enum {FILL, HOLD}.
  - Helper function `count_width(n)` = $clog2(n)+1, reused by the adder wrapper for out_count.
- **Sub-modules:** none. Slot storage, idx counter and FSM live in one module, roughly 150–200 lines.
- **Integration:** out_data connects directly to the adder `inputs`; out_signed drives `signedAddition`.

## Test plan
All cases use INPUTS_AMOUNT=4, P=8.
- **Full group:** reset, then stream 0x01, 0x02, 0x03, 0x04 (in_last on 4th, out_ready=1, in_signed=0).
  - out_valid one cycle after the 4th operand.
  - out_data={1,2,3,4}, out_count=4, out_signed=0.
  - in_ready high again the following cycle.
- **Short group:** stream 0xFF, 0x80 with in_last on 2nd and in_signed=1 on the first.
  - out_data={0xFF,0x80,0,0}, out_count=2, out_signed=1.
  - Downstream signed sum = −129.
- **Backpressure:** full group with out_ready=0 for 5 cycles, and in_valid held high with new data.
  - Outputs frozen and in_ready=0 for all 5 cycles; no operand lost.
  - The next vector starts with the held in_data value once in_ready rises.
- **Sign latched on first operand:** in_signed=1, 0, 0, 0 across a 4-element group.
  - out_signed=1.
- **Reset mid-group:** 2 operands accepted, then rst_n pulsed low asynchronously between edges.
  - Immediately: out_valid=0, in_ready=1, out_data all 0.
  - Next group 0x0A×4 gives out_data={0x0A,0x0A,0x0A,0x0A}, with no stale elements.
- **Single-element group:** one operand 0x7F with in_last.
  - out_count=1, out_data={0x7F,0,0,0}.
